// File: rtl/radio_frame_gate.sv
// radio_frame_gate: buffers the waveform player's free-running AXIS stream and
// releases exactly BEATS_PER_FRAME beats per radio frame, aligned to the
// radio_start_10ms pulse (TUSER on the first beat, TLAST on the last).
// Underflow and misalignment are kept as sticky flags next to a frame counter.
//
// state | meaning
// IDLE  | disabled; input accepted and dropped, FIFO held empty
// ARMED | FIFO filling, waiting for a frame-start pulse with enough prefill
// RUN   | releasing the current frame, counting beats towards TLAST
module radio_frame_gate #(
    parameter int FIFO_DEPTH      = 64,
    parameter int BEATS_PER_FRAME = 3840,
    parameter int PREFILL         = 16
) (
    input  logic        s_axis_aclk,
    input  logic        s_axis_aresetn,
    input  logic        enable,
    input  logic        clear_flags,
    input  logic        radio_start_10ms,
    input  logic [63:0] s_data_tdata,
    input  logic [7:0]  s_data_tkeep,
    input  logic        s_data_tvalid,
    output logic        s_data_tready,
    input  logic        s_data_tlast,
    input  logic        s_data_tuser,
    output logic [63:0] m_data_tdata,
    output logic [7:0]  m_data_tkeep,
    output logic        m_data_tvalid,
    output logic        m_data_tlast,
    output logic        m_data_tuser,
    input  logic        m_data_tready,
    output logic [15:0] frame_count,
    output logic        underflow_flag,
    output logic        misalign_flag,
    output logic [1:0]  gate_state
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_LVL    = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] PREFILL_LVL = CW'(PREFILL);
    localparam logic [15:0]   LAST_BEAT   = 16'(BEATS_PER_FRAME - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2
    } state_t;

    state_t        state;
    logic [71:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] level;
    logic [15:0]   beat_cnt;
    logic [71:0]   head;

    logic fifo_empty;
    logic fifo_full;
    logic flush;
    logic wr_en;
    logic rd_en;
    logic last_hs;
    logic underflow_set;
    logic misalign_set;

    // Upstream tlast/tuser carry no meaning here; the frame structure is regenerated.
    logic unused_in;
    assign unused_in = s_data_tlast ^ s_data_tuser;

    assign fifo_empty = (level == '0);
    assign fifo_full  = (level == FULL_LVL);
    assign flush      = (state == IDLE) || !enable;

    // Ready is forced low while reset is held, otherwise IDLE sinks everything.
    assign s_data_tready = s_axis_aresetn && ((state == IDLE) || !fifo_full);
    assign wr_en         = s_data_tvalid && s_data_tready && (state != IDLE);

    // Outputs are zeroed whenever no beat is presented so reset and idle look clean.
    assign head          = mem[rd_ptr];
    assign m_data_tvalid = (state == RUN) && !fifo_empty;
    assign m_data_tdata  = m_data_tvalid ? head[63:0]  : 64'd0;
    assign m_data_tkeep  = m_data_tvalid ? head[71:64] : 8'd0;
    assign m_data_tuser  = m_data_tvalid && (beat_cnt == 16'd0);
    assign m_data_tlast  = m_data_tvalid && (beat_cnt == LAST_BEAT);
    assign rd_en         = m_data_tvalid && m_data_tready;
    assign last_hs       = rd_en && (beat_cnt == LAST_BEAT);

    assign underflow_set = enable &&
        (((state == ARMED) && radio_start_10ms && (level < PREFILL_LVL)) ||
         ((state == RUN) && fifo_empty && m_data_tready));
    assign misalign_set  = enable && (state == RUN) && radio_start_10ms &&
        (beat_cnt != 16'd0) && !last_hs;

    assign gate_state = state;

    // Storage array; payload only, no reset needed.
    always_ff @(posedge s_axis_aclk) begin
        if (wr_en) begin
            mem[wr_ptr] <= {s_data_tkeep, s_data_tdata};
        end
    end

    // FIFO pointers and fill level; flushed whenever the gate is idle or being disabled.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level <= level + CW'(1);
                2'b01:   level <= level - CW'(1);
                default: level <= level;
            endcase
        end
    end

    // Gate FSM with beat counter, frame counter and sticky flags.
    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state          <= IDLE;
            beat_cnt       <= 16'd0;
            frame_count    <= 16'd0;
            underflow_flag <= 1'b0;
            misalign_flag  <= 1'b0;
        end else begin
            if (underflow_set) begin
                underflow_flag <= 1'b1;
            end else if (clear_flags) begin
                underflow_flag <= 1'b0;
            end

            if (misalign_set) begin
                misalign_flag <= 1'b1;
            end else if (clear_flags) begin
                misalign_flag <= 1'b0;
            end

            if (last_hs) begin
                frame_count <= frame_count + 16'd1;
            end

            if (!enable) begin
                state    <= IDLE;
                beat_cnt <= 16'd0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= ARMED;
                        beat_cnt <= 16'd0;
                    end
                    ARMED: begin
                        if (radio_start_10ms && (level >= PREFILL_LVL)) begin
                            state    <= RUN;
                            beat_cnt <= 16'd0;
                        end
                    end
                    RUN: begin
                        // A start pulse on the closing beat simply chains the next frame.
                        if (last_hs) begin
                            beat_cnt <= 16'd0;
                            if (!radio_start_10ms) begin
                                state <= ARMED;
                            end
                        end else if (radio_start_10ms && (beat_cnt != 16'd0)) begin
                            beat_cnt <= 16'd0;
                        end else if (rd_en) begin
                            beat_cnt <= beat_cnt + 16'd1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        beat_cnt <= 16'd0;
                    end
                endcase
            end
        end
    end

endmodule
